// File: rtl/ctrl_pkg.sv
// Shared encodings and the control-word bundle
// for the 6-stage pipeline main control.
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_NOR = 6'b100111;

  localparam int ALU_W = 4;

  localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_NOR = 4'b1100;

  typedef struct packed {
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_write;
    logic             mem_read;
    logic             alu_src;
    logic             reg_dst;
    logic             branch;
    logic             jump;
    logic             illegal;
    logic [ALU_W-1:0] alu_ctrl;
  } ctrl_word_t;

  localparam ctrl_word_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode/funct decoder producing
// the control word and source-register usage.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic       valid_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output ctrl_word_t word_o,
  output logic       use_rs_o,
  output logic       use_rt_o
);

  always_comb begin
    word_o   = CTRL_BUBBLE;
    use_rs_o = 1'b0;
    use_rt_o = 1'b0;
    if (valid_i) begin
      unique case (opcode_i)
        OP_RTYPE: begin
          word_o.reg_dst   = 1'b1;
          word_o.reg_write = 1'b1;
          use_rs_o         = 1'b1;
          use_rt_o         = 1'b1;
          unique case (funct_i)
            F_ADD: word_o.alu_ctrl = ALU_ADD;
            F_SUB: word_o.alu_ctrl = ALU_SUB;
            F_AND: word_o.alu_ctrl = ALU_AND;
            F_OR:  word_o.alu_ctrl = ALU_OR;
            F_SLT: word_o.alu_ctrl = ALU_SLT;
            F_NOR: word_o.alu_ctrl = ALU_NOR;
            default: begin
              word_o         = CTRL_BUBBLE;
              word_o.illegal = 1'b1;
              use_rs_o       = 1'b0;
              use_rt_o       = 1'b0;
            end
          endcase
        end
        OP_LW: begin
          word_o.alu_src    = 1'b1;
          word_o.mem_to_reg = 1'b1;
          word_o.reg_write  = 1'b1;
          word_o.mem_read   = 1'b1;
          word_o.alu_ctrl   = ALU_ADD;
          use_rs_o          = 1'b1;
        end
        OP_SW: begin
          word_o.alu_src   = 1'b1;
          word_o.mem_write = 1'b1;
          word_o.alu_ctrl  = ALU_ADD;
          use_rs_o         = 1'b1;
          use_rt_o         = 1'b1;
        end
        OP_ADDI: begin
          word_o.alu_src   = 1'b1;
          word_o.reg_write = 1'b1;
          word_o.alu_ctrl  = ALU_ADD;
          use_rs_o         = 1'b1;
        end
        OP_ANDI: begin
          word_o.alu_src   = 1'b1;
          word_o.reg_write = 1'b1;
          word_o.alu_ctrl  = ALU_AND;
          use_rs_o         = 1'b1;
        end
        OP_ORI: begin
          word_o.alu_src   = 1'b1;
          word_o.reg_write = 1'b1;
          word_o.alu_ctrl  = ALU_OR;
          use_rs_o         = 1'b1;
        end
        OP_BEQ: begin
          word_o.branch   = 1'b1;
          word_o.alu_ctrl = ALU_SUB;
          use_rs_o        = 1'b1;
          use_rt_o        = 1'b1;
        end
        OP_J: begin
          word_o.jump = 1'b1;
        end
        default: begin
          word_o.illegal = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Main pipeline control: D/E control register,
// load shadow chain and load-use stall logic.
module pipe_ctrl_unit
  import ctrl_pkg::*;
#(
  parameter int LOAD_USE_DIST = 2,
  parameter int ALU_CTRL_W    = 4,
  parameter int REG_ADDR_W    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_d,
  input  logic [5:0]            opcode_d,
  input  logic [5:0]            funct_d,
  input  logic [REG_ADDR_W-1:0] rs_d,
  input  logic [REG_ADDR_W-1:0] rt_d,
  input  logic [REG_ADDR_W-1:0] rd_d,
  input  logic                  stall_ext,
  input  logic                  flush_e_ext,
  output logic                  jump_d,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  flush_e,
  output logic                  reg_write_e,
  output logic                  mem_to_reg_e,
  output logic                  mem_write_e,
  output logic                  mem_read_e,
  output logic                  alu_src_e,
  output logic                  branch_e,
  output logic [ALU_CTRL_W-1:0] alu_ctrl_e,
  output logic [REG_ADDR_W-1:0] write_reg_e,
  output logic                  illegal_e
);

  typedef logic [REG_ADDR_W-1:0] reg_t;

  ctrl_word_t dec_w;
  logic       use_rs;
  logic       use_rt;
  reg_t       wr_dec;

  ctrl_word_t cw_q, cw_d;
  reg_t       wr_q, wr_d;

  logic [LOAD_USE_DIST-1:0] pend_q, pend_d;
  reg_t dest_q [LOAD_USE_DIST];
  reg_t dest_d [LOAD_USE_DIST];

  logic hit;
  logic load_use;
  logic unused_e;

  ctrl_decode u_dec (
    .valid_i  (valid_d),
    .opcode_i (opcode_d),
    .funct_i  (funct_d),
    .word_o   (dec_w),
    .use_rs_o (use_rs),
    .use_rt_o (use_rt)
  );

  assign jump_d = dec_w.jump;
  assign wr_dec = dec_w.reg_dst ? rd_d : rt_d;

  // $0 is hardwired, so a load to it is never a hazard
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < LOAD_USE_DIST; k++) begin
      if (pend_q[k] && dest_q[k] != '0) begin
        if ((use_rs && dest_q[k] == rs_d) ||
            (use_rt && dest_q[k] == rt_d)) begin
          hit = 1'b1;
        end
      end
    end
    load_use = valid_d & ~dec_w.illegal & hit;
  end

  always_comb begin
    cw_d    = cw_q;
    wr_d    = wr_q;
    pend_d  = pend_q;
    dest_d  = dest_q;
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_e = 1'b0;
    if (reset) begin
      stall_f = 1'b0;
    end else if (stall_ext) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
    end else begin
      for (int k = 1; k < LOAD_USE_DIST; k++) begin
        pend_d[k] = pend_q[k-1];
        dest_d[k] = dest_q[k-1];
      end
      cw_d      = CTRL_BUBBLE;
      wr_d      = '0;
      pend_d[0] = 1'b0;
      dest_d[0] = '0;
      if (flush_e_ext) begin
        flush_e = 1'b1;
      end else if (load_use) begin
        stall_f = 1'b1;
        stall_d = 1'b1;
        flush_e = 1'b1;
      end else begin
        cw_d      = dec_w;
        wr_d      = wr_dec;
        pend_d[0] = dec_w.mem_read;
        dest_d[0] = wr_dec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cw_q   <= CTRL_BUBBLE;
      wr_q   <= '0;
      pend_q <= '0;
      dest_q <= '{default: '0};
    end else begin
      cw_q   <= cw_d;
      wr_q   <= wr_d;
      pend_q <= pend_d;
      dest_q <= dest_d;
    end
  end

  assign reg_write_e  = cw_q.reg_write;
  assign mem_to_reg_e = cw_q.mem_to_reg;
  assign mem_write_e  = cw_q.mem_write;
  assign mem_read_e   = cw_q.mem_read;
  assign alu_src_e    = cw_q.alu_src;
  assign branch_e     = cw_q.branch;
  assign alu_ctrl_e   = ALU_CTRL_W'(cw_q.alu_ctrl);
  assign write_reg_e  = wr_q;
  assign illegal_e    = cw_q.illegal;
  assign unused_e     = cw_q.reg_dst ^ cw_q.jump;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed plus random bench for pipe_ctrl_unit
// against an age-based load-use reference model.
module tb_pipe_ctrl_unit;

  localparam int LUD = 2;

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] RT   = 6'b000000;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] JMP  = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;
  localparam logic [5:0] FADD = 6'b100000;

  logic       clk = 1'b0;
  logic       reset, valid_d, stall_ext, flush_e_ext;
  logic [5:0] opcode_d, funct_d;
  logic [4:0] rs_d, rt_d, rd_d;
  logic       jump_d, stall_f, stall_d, flush_e;
  logic       reg_write_e, mem_to_reg_e, mem_write_e;
  logic       mem_read_e, alu_src_e, branch_e, illegal_e;
  logic [3:0] alu_ctrl_e;
  logic [4:0] write_reg_e;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(
    .LOAD_USE_DIST (LUD),
    .ALU_CTRL_W    (4),
    .REG_ADDR_W    (5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .valid_d      (valid_d),
    .opcode_d     (opcode_d),
    .funct_d      (funct_d),
    .rs_d         (rs_d),
    .rt_d         (rt_d),
    .rd_d         (rd_d),
    .stall_ext    (stall_ext),
    .flush_e_ext  (flush_e_ext),
    .jump_d       (jump_d),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .flush_e      (flush_e),
    .reg_write_e  (reg_write_e),
    .mem_to_reg_e (mem_to_reg_e),
    .mem_write_e  (mem_write_e),
    .mem_read_e   (mem_read_e),
    .alu_src_e    (alu_src_e),
    .branch_e     (branch_e),
    .alu_ctrl_e   (alu_ctrl_e),
    .write_reg_e  (write_reg_e),
    .illegal_e    (illegal_e)
  );

  typedef struct {
    logic       rw, m2r, mw, mr, as, br;
    logic       ill, jmp, urs, urt;
    logic [3:0] alu;
    logic [4:0] wr;
  } exp_t;

  exp_t       e_exp;
  int         q_age [$];
  logic [4:0] q_dest [$];
  int         passed = 0;
  int         fails  = 0;
  int         total  = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  function automatic exp_t dec_model(
      input logic v, input logic [5:0] op,
      input logic [5:0] fn, input logic [4:0] rt,
      input logic [4:0] rd);
    exp_t e;
    e = '{default: '0};
    e.wr = rt;
    if (!v) return e;
    case (op)
      LW:   begin e.as = 1; e.m2r = 1; e.rw = 1; e.mr = 1;
                  e.alu = 4'b0010; e.urs = 1; end
      SW:   begin e.as = 1; e.mw = 1; e.alu = 4'b0010;
                  e.urs = 1; e.urt = 1; end
      ADDI: begin e.as = 1; e.rw = 1; e.alu = 4'b0010;
                  e.urs = 1; end
      ANDI: begin e.as = 1; e.rw = 1; e.alu = 4'b0000;
                  e.urs = 1; end
      ORI:  begin e.as = 1; e.rw = 1; e.alu = 4'b0001;
                  e.urs = 1; end
      BEQ:  begin e.br = 1; e.alu = 4'b0110;
                  e.urs = 1; e.urt = 1; end
      JMP:  e.jmp = 1;
      RT: begin
        e.rw = 1; e.wr = rd; e.urs = 1; e.urt = 1;
        case (fn)
          6'b100000: e.alu = 4'b0010;
          6'b100010: e.alu = 4'b0110;
          6'b100100: e.alu = 4'b0000;
          6'b100101: e.alu = 4'b0001;
          6'b101010: e.alu = 4'b0111;
          6'b100111: e.alu = 4'b1100;
          default: begin
            e = '{default: '0};
            e.ill = 1; e.wr = rt;
          end
        endcase
      end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  task automatic cycle(input logic rst, input logic v,
                       input logic [5:0] op, input logic [5:0] fn,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic sx,
                       input logic fx, output logic st);
    exp_t d;
    logic haz, xs, xf;
    reset = rst; valid_d = v; opcode_d = op; funct_d = fn;
    rs_d = rs; rt_d = rt; rd_d = rd;
    stall_ext = sx; flush_e_ext = fx;
    #1;
    d = dec_model(v, op, fn, rt, rd);
    haz = 1'b0;
    if (v && !d.ill)
      foreach (q_age[i])
        if (q_dest[i] != 0 &&
            ((d.urs && q_dest[i] == rs) ||
             (d.urt && q_dest[i] == rt)))
          haz = 1'b1;
    xs = !rst && (sx || (!fx && haz));
    xf = !rst && !sx && (fx || haz);
    chk("stall_f", stall_f, xs);
    chk("stall_d", stall_d, xs);
    chk("flush_e", flush_e, xf);
    chk("jump_d", jump_d, d.jmp);
    st = stall_d;
    if (rst) begin
      e_exp = '{default: '0};
      q_age.delete(); q_dest.delete();
    end else if (!sx) begin
      for (int i = q_age.size() - 1; i >= 0; i--) begin
        q_age[i]++;
        if (q_age[i] >= LUD) begin
          q_age.delete(i); q_dest.delete(i);
        end
      end
      if (fx || haz) e_exp = '{default: '0};
      else begin
        e_exp = d;
        if (d.mr) begin
          q_age.push_back(0); q_dest.push_back(d.wr);
        end
      end
    end
    @(posedge clk); #1;
    chk("reg_write_e", reg_write_e, e_exp.rw);
    chk("mem_to_reg_e", mem_to_reg_e, e_exp.m2r);
    chk("mem_write_e", mem_write_e, e_exp.mw);
    chk("mem_read_e", mem_read_e, e_exp.mr);
    chk("alu_src_e", alu_src_e, e_exp.as);
    chk("branch_e", branch_e, e_exp.br);
    chk("alu_ctrl_e", alu_ctrl_e, e_exp.alu);
    chk("write_reg_e", write_reg_e, e_exp.wr);
    chk("illegal_e", illegal_e, e_exp.ill);
    @(negedge clk);
  endtask

  task automatic feed(input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, output int n);
    logic st;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, op, fn, rs, rt, rd, 0, 0, st);
      if (!st) break;
      n++;
    end
  endtask

  initial begin
    logic st;
    int n;
    logic [5:0] fns [6];
    logic [3:0] alus [6];
    logic [5:0] ops [9];
    logic [5:0] rfn [7];
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;
    logic v;
    fns  = '{6'b100000, 6'b100010, 6'b100100,
             6'b100101, 6'b101010, 6'b100111};
    alus = '{4'b0010, 4'b0110, 4'b0000,
             4'b0001, 4'b0111, 4'b1100};
    ops  = '{LW, SW, RT, ADDI, ANDI, ORI, BEQ, JMP, BAD};
    rfn  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
             6'b101010, 6'b100111, 6'b000001};
    e_exp = '{default: '0};
    @(negedge clk);

    repeat (2) cycle(1, 1, LW, 0, 1, 8, 0, 0, 0, st);
    chk("rst_mem_read_e", mem_read_e, 1'b0);
    cycle(0, 1, LW, 0, 1, 8, 0, 0, 0, st);
    chk("first_mem_read_e", mem_read_e, 1'b1);
    chk("first_alu_ctrl_e", alu_ctrl_e, 4'b0010);

    for (int i = 0; i < 6; i++) begin
      cycle(0, 1, RT, fns[i], 1, 2, 3, 0, 0, st);
      chk("rtype_alu", alu_ctrl_e, alus[i]);
      chk("rtype_wr", write_reg_e, 5'd3);
    end

    feed(LW, 0, 1, 8, 0, n);
    feed(RT, FADD, 8, 2, 3, n);
    chk("lu_dist1_stalls", n, 2);
    feed(LW, 0, 1, 0, 0, n);
    feed(RT, FADD, 0, 2, 3, n);
    chk("lu_dest0_stalls", n, 0);

    feed(LW, 0, 1, 9, 0, n);
    feed(ADDI, 0, 1, 2, 0, n);
    feed(SW, 0, 1, 9, 0, n);
    chk("lu_dist2_stalls", n, 1);
    feed(LW, 0, 1, 9, 0, n);
    feed(ADDI, 0, 1, 2, 0, n);
    feed(ADDI, 0, 1, 2, 0, n);
    feed(BEQ, 0, 4, 9, 0, n);
    chk("lu_dist3_stalls", n, 0);

    feed(LW, 0, 1, 10, 0, n);
    cycle(0, 1, RT, FADD, 10, 2, 3, 0, 1, st);
    chk("flush_wins_stall_d", st, 1'b0);
    repeat (2) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, st);

    feed(LW, 0, 1, 11, 0, n);
    cycle(0, 1, RT, FADD, 11, 2, 3, 0, 0, st);
    repeat (3) cycle(0, 1, RT, FADD, 11, 2, 3, 1, 0, st);
    feed(RT, FADD, 11, 2, 3, n);
    chk("stall_ext_resume", n, 1);

    feed(LW, 0, 1, 12, 0, n);
    cycle(0, 1, BAD, 0, 12, 12, 12, 0, 0, st);
    chk("ill_op_flag", illegal_e, 1'b1);
    chk("ill_op_nostall", st, 1'b0);
    cycle(0, 1, RT, 6'b000001, 12, 12, 12, 0, 0, st);
    chk("ill_fn_flag", illegal_e, 1'b1);
    chk("ill_fn_rw", reg_write_e, 1'b0);
    cycle(0, 1, JMP, 0, 0, 0, 0, 0, 0, st);

    feed(LW, 0, 1, 13, 0, n);
    cycle(0, 1, RT, FADD, 13, 2, 3, 0, 0, st);
    cycle(1, 1, RT, FADD, 13, 2, 3, 0, 0, st);
    feed(RT, FADD, 13, 2, 3, n);
    chk("post_reset_stalls", n, 0);

    st = 1'b0;
    op = LW; fn = FADD; rs = 0; rt = 0; rd = 0; v = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (!st) begin
        op = ops[$urandom_range(0, 8)];
        fn = rfn[$urandom_range(0, 6)];
        rs = 5'($urandom_range(0, 3));
        rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3));
        v  = ($urandom_range(0, 9) != 0);
      end
      cycle(($urandom_range(0, 59) == 0), v, op, fn, rs, rt, rd,
            ($urandom_range(0, 11) == 0),
            ($urandom_range(0, 11) == 0), st);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
